// File: rtl/screen_renderer.sv
// screen_renderer
//   Full-screen image renderer with frame-synchronous fade. It maps the
//   VGA scan position to a downscaled image ROM address. It expands
//   RGB332 ROM data to RGB444 by bit replication. It scales each channel
//   by a brightness level (0..16) that a fade state machine drives.
//
// Ports
//   clk            pixel clock
//   reset          synchronous, active-low reset
//   x, y, de       scan position and display enable from the timing generator
//   frame_start    one-cycle pulse at the start of each frame
//   start_fade_in  command: ramp level up to 16
//   start_fade_out command: ramp level down to 0 (wins if both asserted)
//   rom_addr       registered address to a 1-cycle synchronous image ROM
//   rom_data       RGB332 data, valid one cycle after rom_addr
//   pix_out        RGB444 {R4,G4,B4}, zero outside the image or when de = 0
//   pix_valid      pix_out belongs to a de = 1 sample
//   level          current brightness 0..16
//   fade_done      one-cycle pulse when a fade completes or is a no-op
//
// Pipeline: sample/address (edge N), ROM read (N+1), expand/scale/out (N+2).

module chan_scale (
    input  logic [3:0] c4,
    input  logic [4:0] lvl,
    output logic [3:0] scaled
);
    // 15 * 16 = 240, so the 8-bit product never overflows.
    assign scaled = 4'((8'(c4) * 8'(lvl)) >> 4);
endmodule

module screen_renderer #(
    parameter int SCALE_SHIFT      = 2,
    parameter int IMG_W            = 160,
    parameter int IMG_H            = 120,
    parameter int ADDR_W           = 15,
    parameter int FADE_STEP_FRAMES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    input  logic              de,
    input  logic              frame_start,
    input  logic              start_fade_in,
    input  logic              start_fade_out,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [11:0]       pix_out,
    output logic              pix_valid,
    output logic [4:0]        level,
    output logic              fade_done
);
    localparam int STAGES = 2;
    localparam int FCNT_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FADE_STEP_FRAMES - 1);
    localparam logic [4:0]  LVL_MAX = 5'd16;
    localparam logic [31:0] IMG_W_U = IMG_W;
    localparam logic [31:0] IMG_H_U = IMG_H;

    typedef enum logic [1:0] {HOLD, FADE_IN, FADE_OUT} fade_state_t;

    // ---------------- stage 1: position -> ROM address ----------------
    logic [9:0]        col;
    logic [8:0]        row;
    logic              in_img;
    logic [ADDR_W-1:0] addr_nxt;

    assign col      = x >> SCALE_SHIFT;
    assign row      = y >> SCALE_SHIFT;
    assign in_img   = de && (32'(col) < IMG_W_U) && (32'(row) < IMG_H_U);
    assign addr_nxt = ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);

    // vld_pipe carries de; pix_valid is its last tap. img_pipe carries
    // in_img up to the stage that consumes rom_data.
    logic [STAGES:0]   vld_pipe;
    logic [STAGES-1:0] img_pipe;

    // ---------------- stage 3: expand + scale ----------------
    logic [2:0][3:0] rgb4;
    logic [2:0][3:0] rgb_scaled;

    assign rgb4[2] = {rom_data[7:5], rom_data[7]};
    assign rgb4[1] = {rom_data[4:2], rom_data[4]};
    assign rgb4[0] = {rom_data[1:0], rom_data[1:0]};

    for (genvar i = 0; i < 3; i++) begin : g_chan
        chan_scale u_scale (
            .c4    (rgb4[i]),
            .lvl   (level),
            .scaled(rgb_scaled[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe <= '0;
            img_pipe <= '0;
            rom_addr <= '0;
            pix_out  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], de};
            img_pipe <= {img_pipe[0], in_img};
            // Outside the image the ROM keeps reading the last address;
            // its data is masked at stage 3 anyway.
            if (in_img)
                rom_addr <= addr_nxt;
            pix_out <= img_pipe[STAGES-1] ? rgb_scaled : 12'h000;
        end
    end

    assign pix_valid = vld_pipe[STAGES];

    // ---------------- fade state machine ----------------
    fade_state_t       state;
    logic [FCNT_W-1:0] fcnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= HOLD;
            fcnt      <= '0;
            level     <= '0;
            fade_done <= 1'b0;
        end else begin
            fade_done <= 1'b0;
            case (state)
                HOLD: begin
                    if (start_fade_out) begin
                        if (level != 5'd0) begin
                            state <= FADE_OUT;
                            fcnt  <= '0;
                        end else begin
                            fade_done <= 1'b1;
                        end
                    end else if (start_fade_in) begin
                        if (level != LVL_MAX) begin
                            state <= FADE_IN;
                            fcnt  <= '0;
                        end else begin
                            fade_done <= 1'b1;
                        end
                    end
                end

                FADE_IN: begin
                    if (start_fade_out) begin
                        // Reversing at the floor has nothing left to do,
                        // so it completes immediately.
                        if (level == 5'd0) begin
                            state     <= HOLD;
                            fade_done <= 1'b1;
                        end else begin
                            state <= FADE_OUT;
                            fcnt  <= '0;
                        end
                    end else if (frame_start) begin
                        if (fcnt == FCNT_LAST) begin
                            fcnt  <= '0;
                            level <= level + 5'd1;
                            if (level == LVL_MAX - 5'd1) begin
                                state     <= HOLD;
                                fade_done <= 1'b1;
                            end
                        end else begin
                            fcnt <= fcnt + FCNT_W'(1);
                        end
                    end
                end

                FADE_OUT: begin
                    if (start_fade_in && !start_fade_out) begin
                        if (level == LVL_MAX) begin
                            state     <= HOLD;
                            fade_done <= 1'b1;
                        end else begin
                            state <= FADE_IN;
                            fcnt  <= '0;
                        end
                    end else if (frame_start) begin
                        if (fcnt == FCNT_LAST) begin
                            fcnt  <= '0;
                            level <= level - 5'd1;
                            if (level == 5'd1) begin
                                state     <= HOLD;
                                fade_done <= 1'b1;
                            end
                        end else begin
                            fcnt <= fcnt + FCNT_W'(1);
                        end
                    end
                end

                default: state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_screen_renderer.sv
// Scoreboard bench for screen_renderer: stimulus pushes expected pixels,
// a negedge monitor pops them whenever pix_valid is high.

module tb_screen_renderer;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        de;
    logic        frame_start;
    logic        start_fade_in;
    logic        start_fade_out;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic [11:0] pix_out;
    logic        pix_valid;
    logic [4:0]  level;
    logic        fade_done;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    logic [11:0] exp_q[$];

    screen_renderer dut (
        .clk           (clk),
        .reset         (reset),
        .x             (x),
        .y             (y),
        .de            (de),
        .frame_start   (frame_start),
        .start_fade_in (start_fade_in),
        .start_fade_out(start_fade_out),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .pix_out       (pix_out),
        .pix_valid     (pix_valid),
        .level         (level),
        .fade_done     (fade_done)
    );

    always #5 clk = ~clk;

    // Image content: two hand-picked entries, a simple pattern elsewhere.
    function automatic logic [7:0] rom_fn(input logic [14:0] a);
        if (a == 15'd323) return 8'hFF;
        if (a == 15'd324) return 8'hAE;
        return a[7:0] ^ 8'h3C;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops on every valid pixel; idle outputs must be black.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (pix_valid) begin
                if (exp_q.size() == 0) begin
                    check("pix_unexpected", 32'(pix_out), 32'hFFFF_FFFF);
                end else begin
                    logic [11:0] e;
                    e = exp_q.pop_front();
                    check("pix_out", 32'(pix_out), 32'(e));
                end
            end else begin
                check("pix_idle_zero", 32'(pix_out), 32'h0);
            end
        end
        if (fade_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input logic [9:0] xx, input logic [8:0] yy,
                            input logic dd, input logic [11:0] ex);
        x = xx; y = yy; de = dd;
        if (dd) exp_q.push_back(ex);
        tick();
        de = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic cmd(input logic fi, input logic fo);
        start_fade_in = fi; start_fade_out = fo;
        tick();
        start_fade_in = 1'b0; start_fade_out = 1'b0;
    endtask

    initial begin
        int d0;
        reset = 1'b0; x = '0; y = '0; de = 1'b0;
        frame_start = 1'b0; start_fade_in = 1'b0; start_fade_out = 1'b0;

        // reset state
        idle(3);
        check("rst_rom_addr", 32'(rom_addr), 0);
        check("rst_pix_out", 32'(pix_out), 0);
        check("rst_pix_valid", 32'(pix_valid), 0);
        check("rst_level", 32'(level), 0);
        check("rst_fade_done", 32'(fade_done), 0);
        reset = 1'b1;
        idle(2);

        // level 0: addresses still generated, pixels black
        drive_px(10'd13, 9'd9, 1'b1, 12'h000);
        check("addr_13_9", 32'(rom_addr), 323);
        drive_px(10'd16, 9'd9, 1'b1, 12'h000);
        check("addr_16_9", 32'(rom_addr), 324);
        idle(4);

        // fade in: one step per 4 frames, done on the 64th pulse
        d0 = done_cnt;
        cmd(1'b1, 1'b0);
        check("fadein_start_done", 32'(fade_done), 0);
        for (int k = 1; k <= 64; k++) begin
            frame_pulse();
            check("fadein_level", 32'(level), 32'(k / 4));
            check("fadein_done", 32'(fade_done), (k == 64) ? 1 : 0);
            if (k == 32) begin
                drive_px(10'd16, 9'd9, 1'b1, 12'h535);
                drive_px(10'd13, 9'd9, 1'b1, 12'h777);
                idle(4);
            end
            tick();
        end
        check("fadein_done_count", 32'(done_cnt - d0), 1);
        idle(2);
        check("fadein_hold_level", 32'(level), 16);

        // full brightness, out-of-image and blanking
        drive_px(10'd13, 9'd9, 1'b1, 12'hFFF);
        check("addr_full_13_9", 32'(rom_addr), 323);
        drive_px(10'd16, 9'd9, 1'b1, 12'hB6A);
        drive_px(10'd640, 9'd9, 1'b1, 12'h000);
        check("addr_hold_col160", 32'(rom_addr), 324);
        drive_px(10'd20, 9'd9, 1'b0, 12'h000);
        check("addr_hold_de0", 32'(rom_addr), 324);
        drive_px(10'd100, 9'd50, 1'b1, 12'hB25);
        check("addr_100_50", 32'(rom_addr), 1945);
        drive_px(10'd639, 9'd479, 1'b1, 12'hD0F);
        check("addr_last", 32'(rom_addr), 19199);
        drive_px(10'd0, 9'd480, 1'b1, 12'h000);
        check("addr_hold_row120", 32'(rom_addr), 19199);
        idle(4);

        // no-op fade in at 16
        d0 = done_cnt;
        cmd(1'b1, 1'b0);
        check("noop_in_done", 32'(fade_done), 1);
        check("noop_in_level", 32'(level), 16);
        tick();
        check("noop_in_done_clr", 32'(fade_done), 0);
        check("noop_in_count", 32'(done_cnt - d0), 1);

        // fade out to 10, then reset mid-fade with pixels in flight
        cmd(1'b0, 1'b1);
        for (int k = 1; k <= 24; k++) begin
            frame_pulse();
            check("fadeout_level", 32'(level), 32'(16 - k / 4));
        end
        check("fadeout_level10", 32'(level), 10);
        d0 = done_cnt;
        x = 10'd0; y = 9'd0; de = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1; de = 1'b0;
        check("midrst_level", 32'(level), 0);
        check("midrst_done", 32'(fade_done), 0);
        check("midrst_pix_valid", 32'(pix_valid), 0);
        for (int k = 0; k < 4; k++) frame_pulse();
        check("midrst_hold_level", 32'(level), 0);
        check("midrst_no_done", 32'(done_cnt - d0), 0);

        // fade in to 7, reverse with both commands, fade to 0
        d0 = done_cnt;
        cmd(1'b1, 1'b0);
        for (int k = 1; k <= 28; k++) begin
            frame_pulse();
            check("rev_up_level", 32'(level), 32'(k / 4));
        end
        check("rev_level7", 32'(level), 7);
        cmd(1'b1, 1'b1);
        check("rev_cmd_done", 32'(fade_done), 0);
        for (int k = 1; k <= 28; k++) begin
            frame_pulse();
            check("rev_down_level", 32'(level), 32'(7 - k / 4));
            check("rev_down_done", 32'(fade_done), (k == 28) ? 1 : 0);
        end
        tick();
        check("rev_done_count", 32'(done_cnt - d0), 1);

        // no-op fade out at 0
        d0 = done_cnt;
        cmd(1'b0, 1'b1);
        check("noop_out_done", 32'(fade_done), 1);
        check("noop_out_level", 32'(level), 0);
        tick();
        check("noop_out_done_clr", 32'(fade_done), 0);
        check("noop_out_count", 32'(done_cnt - d0), 1);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/screen_renderer.md
# screen_renderer

Parametrised, pipelined full-screen image renderer with hardware fade-in/fade-out. It is the next generation of the splash-screen lookup. It maps the VGA scan position to a downscaled image ROM address and expands RGB332 ROM data to RGB444 by bit replication. It applies a frame-synchronous brightness level under control of a fade state machine. It sits between the VGA timing generator and the display mux, driving a synchronous (1-cycle) image ROM.

## Interface

- SCALE_SHIFT, 2, log2 of the pixel replication factor (col = x >> SCALE_SHIFT, row = y >> SCALE_SHIFT)
- IMG_W, 160, image width in ROM pixels
- IMG_H, 120, image height in ROM pixels
- ADDR_W, 15, ROM address width; must satisfy IMG_W*IMG_H <= 2**ADDR_W
- FADE_STEP_FRAMES, 4, frames per brightness step (>= 1)
- clk  in  1  pixel clock
- reset  in  1  reset, synchronous, active-low
- x  in  10  scan column
- y  in  9  scan row
- de  in  1  display-enable for x/y this cycle
- frame_start  in  1  one-cycle pulse at start of each frame
- start_fade_in  in  1  one-cycle command: ramp brightness to full
- start_fade_out  in  1  one-cycle command: ramp brightness to black
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  8  RGB332 ROM data, valid one cycle after rom_addr
- pix_out  out  12  RGB444 pixel {R4,G4,B4}
- pix_valid  out  1  pix_out corresponds to a de=1 sample
- level  out  5  current brightness, 0..16
- fade_done  out  1  one-cycle pulse when a fade completes

## Operation

- Stage 1, registered: col = x >> SCALE_SHIFT, row = y >> SCALE_SHIFT. in_img = de & (col < IMG_W) & (row < IMG_H). rom_addr = row*IMG_W + col, truncated to ADDR_W, only when in_img; otherwise rom_addr holds its previous value.
- Stage 2: de and in_img are delayed one register to align with rom_data.
- Stage 3, registered:
  - Expansion: R4 = {r[2:0], r[2]}, G4 = {g[2:0], g[2]}, B4 = {b[1:0], b[1:0]}, where r = rom_data[7:5], g = [4:2], b = [1:0].
  - Scaling: each channel becomes (c4 * level) >> 4 using an 8-bit product. level 16 gives the unchanged value; level 0 gives 0.
  - Output: pix_out = scaled value if aligned in_img, else 12'h000. pix_valid = aligned de. When de = 0, pix_out = 0.
- Fade FSM states: HOLD, FADE_IN, FADE_OUT. A frame counter fcnt (0..FADE_STEP_FRAMES-1) advances only on frame_start.
  - HOLD, start_fade_in: if level < 16, go to FADE_IN and clear fcnt. If level = 16, pulse fade_done the next cycle and stay in HOLD.
  - HOLD, start_fade_out: if level > 0, go to FADE_OUT and clear fcnt. If level = 0, pulse fade_done and stay in HOLD.
  - FADE_IN: on frame_start, if fcnt = FADE_STEP_FRAMES-1, clear fcnt and increment level; otherwise increment fcnt. When level reaches 16, return to HOLD with fade_done = 1 in the same cycle as that level update.
  - FADE_OUT: mirror of FADE_IN, decrementing level to 0.
  - Reversal: start_fade_out during FADE_IN switches to FADE_OUT from the current level and clears fcnt. Symmetric for start_fade_in during FADE_OUT.
  - A same-direction command during a fade is ignored.
  - If both commands are asserted in one cycle, start_fade_out wins.
- level changes only on frame_start edges, so brightness is constant within a frame.

## Timing

- Reset (reset = 0 at a clk edge):
  - Outputs: rom_addr = 0, pix_out = 0, pix_valid = 0, level = 0, fade_done = 0.
  - Internal: state HOLD, fcnt = 0, all pipeline valid bits cleared.
- Reset mid-fade abandons the fade without a fade_done pulse.
- Latency: x/y/de sampled at edge N → rom_addr updated at N → rom_data valid after N+1 → pix_out and pix_valid updated at N+2. Throughput is one pixel per clock with no stalls.
- Brightness sampling: the level applied at stage 3 is the level at that edge. A level change on frame_start therefore affects pixels leaving stage 3 from the next edge onward.
- Frame cadence: a fade from 0 to 16 takes exactly 16*FADE_STEP_FRAMES frame_start pulses after the command.
- fade_done is high for exactly one cycle per completed or no-op fade.

## Test plan

- Address mapping: defaults, de = 1, x = 13, y = 9 → rom_addr = 2*160 + 3 = 323 one edge later. With rom_data = 8'hFF and level = 16, pix_out = 12'hFFF two edges after sampling.
- Out-of-image and blanking: x = 640 (col 160) with de = 1 → pix_out = 0, pix_valid = 1, rom_addr unchanged. With de = 0 → pix_valid = 0, pix_out = 0.
- Expansion and scaling: rom_data = 8'b101_011_10 at level 16 → pix_out = 12'hB6A. At level 8 → 12'h535. At level 0 → 12'h000.
- Fade-in: from reset, FADE_STEP_FRAMES = 4, pulse start_fade_in, then 64 frame_start pulses → level rises 1 every 4 frames. fade_done pulses once, coincident with the 64th pulse's update. State ends in HOLD.
- Reversal and priority:
  - At level 7 during FADE_IN, assert start_fade_in and start_fade_out together → FADE_OUT; level reaches 0 after 28 more frames, then fade_done.
  - A repeat start_fade_out at level 0 → single fade_done pulse with no level change.
- Reset mid-fade: assert reset = 0 for one cycle at level 10 during FADE_OUT → next cycle level = 0, HOLD, no fade_done pulse, pix_valid = 0.
